// File: rtl/logic_op_sequencer.sv
// Command front-end for the 8-bit logic unit: a small command FIFO feeding a
// registered AND/OR/NOT/XOR stage with accumulator chaining and a valid/ready result slot.
module logic_op_sequencer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic                     cmd_acc,
   input  logic [WIDTH-1:0]         cmd_a,
   input  logic [WIDTH-1:0]         cmd_b,
   input  logic                     acc_clr,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_data,
   output logic                     res_zero,
   output logic                     res_parity,
   output logic                     res_ones,
   output logic [WIDTH-1:0]         acc_out,
   output logic [$clog2(DEPTH):0]   cmd_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_NOT = 2'b10,
      OP_XOR = 2'b11
   } op_e;

   typedef struct packed {
      op_e              op;
      logic             acc;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } cmd_t;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } slot_e;

   cmd_t             mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   slot_e            state_q, state_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_zero_q, res_zero_d;
   logic             res_parity_q, res_parity_d;
   logic             res_ones_q, res_ones_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             push;
   logic             load;
   cmd_t             push_cmd;
   cmd_t             head;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] result;

   // Handshake qualifiers; ready depends on occupancy only.
   assign cmd_ready = (count_q < CW'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign load      = (count_q != '0) && (!res_valid || res_ready);

   assign push_cmd  = '{op: op_e'(cmd_op), acc: cmd_acc, a: cmd_a, b: cmd_b};
   assign head      = mem_q[rd_ptr_q];

   // NOTE: the command storage has no reset; pointers and count alone decide
   // which entries are live, so stale contents after reset are never read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_cmd;
      end
   end

   // NOTE: every variable assigned in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (load) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, load})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Output slot FSM: state register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Output slot FSM: next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: if (load) state_d = S_FULL;
         S_FULL:  if (res_ready && !load) state_d = S_EMPTY;
         default: state_d = S_EMPTY;
      endcase
   end

   // Output slot FSM: outputs.
   always_comb begin
      res_valid = (state_q == S_FULL);
   end

   // Operand A comes from the accumulator as it stands at execute time.
   always_comb begin
      op_a = head.acc ? acc_q : head.a;
      case (head.op)
         OP_AND:  result = op_a & head.b;
         OP_OR:   result = op_a | head.b;
         OP_NOT:  result = ~op_a;
         OP_XOR:  result = op_a ^ head.b;
         default: result = '0;
      endcase
   end

   always_comb begin
      res_data_d   = res_data_q;
      res_zero_d   = res_zero_q;
      res_parity_d = res_parity_q;
      res_ones_d   = res_ones_q;
      if (load) begin
         res_data_d   = result;
         res_zero_d   = (result == '0);
         res_parity_d = ^result;
         res_ones_d   = &result;
      end
   end

   // A clear wins over the accumulator write of a simultaneous load.
   always_comb begin
      acc_d = acc_q;
      if (acc_clr) begin
         acc_d = '0;
      end else if (load) begin
         acc_d = result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         res_data_q   <= '0;
         res_zero_q   <= 1'b0;
         res_parity_q <= 1'b0;
         res_ones_q   <= 1'b0;
         acc_q        <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         res_data_q   <= res_data_d;
         res_zero_q   <= res_zero_d;
         res_parity_q <= res_parity_d;
         res_ones_q   <= res_ones_d;
         acc_q        <= acc_d;
      end
   end

   assign res_data   = res_data_q;
   assign res_zero   = res_zero_q;
   assign res_parity = res_parity_q;
   assign res_ones   = res_ones_q;
   assign acc_out    = acc_q;
   assign cmd_count  = count_q;

endmodule

// File: doc/logic_op_sequencer.md
Name: logic_op_sequencer

Overview:
- Command front-end for the 8-bit logic unit: queues (opcode, A, B) commands and executes AND/OR/NOT/XOR one per cycle.
- Registers each result with status flags and presents it downstream on a valid/ready handshake.
- Keeps an accumulator so that chained operations can use the previous result as operand A.
- Sits between the instruction decoder and the ALU result bus.

Parameters:
WIDTH, 8, operand/result width in bits
DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept (= count < DEPTH)
cmd_op  input  2  00 AND, 01 OR, 10 NOT, 11 XOR
cmd_acc  input  1  1: operand A = accumulator at execute time; cmd_a ignored
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B (ignored for NOT)
acc_clr  input  1  synchronous accumulator clear
res_valid  output  1  result register holds unconsumed result
res_ready  input  1  downstream accepts result
res_data  output  WIDTH  result
res_zero  output  1  res_data == 0
res_parity  output  1  XOR-reduce of res_data (1 = odd number of ones)
res_ones  output  1  res_data all ones
acc_out  output  WIDTH  accumulator value
cmd_count  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - Outputs: res_valid=0, res_data=0, res_zero=0, res_parity=0, res_ones=0, acc_out=0, cmd_count=0, cmd_ready=1.
  - FIFO pointers clear; all queued commands are discarded.
- Push: on an edge where cmd_valid && cmd_ready, the command is written at the tail. cmd_ready depends only on count, never on cmd_valid or res_ready.
- Output slot is a 2-state FSM:
  - EMPTY --load--> FULL.
  - FULL --res_ready && !load--> EMPTY.
  - FULL --res_ready && load--> FULL, with the new result (back-to-back, 1 result/cycle).
  - FULL && !res_ready: hold res_data and all flags stable.
- Load condition: FIFO non-empty && (!res_valid || res_ready). On load, the same edge:
  - pops the head;
  - computes A op B from the head, with A = acc_out when cmd_acc=1;
  - writes res_data and flags;
  - writes acc_out <= result.
- No bypass path: a command accepted at edge N into an empty FIFO with an EMPTY slot gives res_valid=1 after edge N+1. Minimum latency is 1 cycle; throughput is 1 per cycle.
- Simultaneous push and pop: count is unchanged. Push when full is impossible because cmd_ready=0.
- Pointers wrap modulo DEPTH.
- NOT: result = ~A; cmd_b is don't-care.
- Accumulator chaining uses acc at execute time. A back-to-back cmd_acc command therefore sees the result loaded on the previous edge.
- acc_clr: acc_out <= 0 at the next edge, and takes priority over a simultaneous load's acc write. The loaded result itself still appears on res_data.
- Flags are registered with res_data and never change while res_valid=1 && !res_ready.
- cmd_count is the registered occupancy, 0..DEPTH.

Test Plan:
- Single ops, res_ready=1:
  - AND F0,3C -> res_data 30, zero 0, parity 0, ones 0.
  - OR F0,0F -> FF, ones 1, parity 0.
  - XOR AA,AA -> 00, zero 1.
  - NOT 5A (b=FF) -> A5, parity 0.
  - Each result has res_valid high exactly 1 cycle, 1 cycle after acceptance.
- Accumulator chain, issued back-to-back:
  - OR 0F,00 -> 0F.
  - XOR acc,FF -> F0.
  - NOT acc -> 0F.
  - Final acc_out = 0F; results arrive on 3 consecutive cycles.
- Backpressure, res_ready=0, DEPTH=4:
  - Offer 6 commands: 5 accepted (1 in output slot, 4 in FIFO), cmd_count=4, cmd_ready=0, 6th stalls.
  - res_data and flags stay stable throughout.
  - Then res_ready=1: all 6 drain in order, one per cycle, with no loss or duplication.
- acc_clr during load:
  - Execute OR 0F,00 with acc_clr=1 on the same edge -> res_data 0F, acc_out 00.
  - Next XOR acc,3C -> 3C.
- Reset mid-operation:
  - With 3 queued commands and res_valid=1, pulse rst_n low between edges.
  - res_valid, cmd_count and acc_out go to 0 immediately, asynchronously; cmd_ready=1.
  - After release, a new AND FF,81 -> 81, parity 0, and no stale results appear.
- Wrap-around: stream 20 commands with random res_ready (~50% duty) -> the output sequence matches a reference model exactly across pointer wrap.
